// File: rtl/alu_pkg.sv
// Shared ALU definitions: divide opcodes, divider sequencer states and opcode helpers.
package alu_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_DIV  = 5'b10001;
    localparam logic [OP_W-1:0] OP_DIVU = 5'b10101;
    localparam logic [OP_W-1:0] OP_REM  = 5'b11001;
    localparam logic [OP_W-1:0] OP_REMU = 5'b11101;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } div_state_t;

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_div(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [OP_W-1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int unsigned n = 32
) (
    input  logic [n:0]   rem_i,
    input  logic         msb_i,
    input  logic [n-1:0] divisor_i,
    output logic [n:0]   rem_o,
    output logic         qbit_o
);

    logic [n+1:0] shifted;
    logic [n+1:0] diff;

    always_comb begin
        shifted = {rem_i, msb_i};
        diff    = shifted - {2'b00, divisor_i};
        qbit_o  = ~diff[n+1];
        rem_o   = diff[n+1] ? shifted[n:0] : diff[n:0];
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer with sign fix-up and one-cycle special cases.
// Optional DIV_REUSE_EN: single-entry cache of the last completed operands and results.
module div_seq
    import alu_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic            clock,
    input  logic            nReset,
    input  logic            Start,
    input  logic [OP_W-1:0] AluOp,
    input  logic [n-1:0]    A,
    input  logic [n-1:0]    B,
    input  logic            Flush,
    output logic            Busy,
    output logic            Done,
    output logic [n-1:0]    Result
);

    localparam int unsigned  CNT_W   = $clog2(n);
    localparam logic [n-1:0] MIN_NEG = {1'b1, {(n-1){1'b0}}};

    div_state_t state_q, state_d;

    // dq holds the dividend; quotient bits shift in from the bottom as it drains
    logic [n-1:0] dq_q, dq_d;
    logic [n-1:0] dvs_q, dvs_d;
    logic [n:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic         sgn_q, sgn_d;
    logic         isrem_q, isrem_d;
    logic         qneg_q, qneg_d;
    logic         rneg_q, rneg_d;
    logic [n-1:0] result_q, result_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;

`ifdef DIV_REUSE_EN
    logic [n-1:0] opa_q, opa_d;
    logic [n-1:0] opb_q, opb_d;
    logic [n-1:0] ca_q, ca_d;
    logic [n-1:0] cb_q, cb_d;
    logic         cs_q, cs_d;
    logic [n-1:0] cq_q, cq_d;
    logic [n-1:0] cr_q, cr_d;
    logic         cv_q, cv_d;
    logic         hit;
`endif

    logic [n:0]   step_rem;
    logic         step_qbit;
    logic         start_ok;
    logic         op_signed;
    logic         op_rem;
    logic         special;
    logic [n-1:0] sp_quot;
    logic [n-1:0] sp_rem;
    logic [n-1:0] abs_dq;
    logic [n-1:0] abs_dvs;
    logic [n-1:0] q_fin;
    logic [n-1:0] r_fin;

    div_step #(.n(n)) u_step (
        .rem_i     (rem_q),
        .msb_i     (dq_q[n-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // Operand decode and one-cycle special-case results
    always_comb begin
        start_ok  = Start && is_div_op(AluOp);
        op_signed = is_signed_div(AluOp);
        op_rem    = is_rem_op(AluOp);
        special   = 1'b0;
        sp_quot   = '1;
        sp_rem    = A;
        if (B == '0) begin
            special = 1'b1;
        end else if (op_signed && (A == MIN_NEG) && (B == '1)) begin
            special = 1'b1;
            sp_quot = A;
            sp_rem  = '0;
        end
        abs_dq  = dq_q[n-1]  ? ('0 - dq_q)  : dq_q;
        abs_dvs = dvs_q[n-1] ? ('0 - dvs_q) : dvs_q;
        q_fin   = qneg_q ? ('0 - dq_q) : dq_q;
        r_fin   = rneg_q ? ('0 - rem_q[n-1:0]) : rem_q[n-1:0];
`ifdef DIV_REUSE_EN
        hit = cv_q && (A == ca_q) && (B == cb_q) && (op_signed == cs_q);
`endif
    end

    always_comb begin
        state_d  = state_q;
        dq_d     = dq_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        sgn_d    = sgn_q;
        isrem_d  = isrem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
`ifdef DIV_REUSE_EN
        opa_d = opa_q;
        opb_d = opb_q;
        ca_d  = ca_q;
        cb_d  = cb_q;
        cs_d  = cs_q;
        cq_d  = cq_q;
        cr_d  = cr_q;
        cv_d  = cv_q;
`endif

        if (Flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
`ifdef DIV_REUSE_EN
                        if (hit) begin
                            result_d = op_rem ? cr_q : cq_q;
                            state_d  = DONE;
                        end else
`endif
                        if (special) begin
                            result_d = op_rem ? sp_rem : sp_quot;
                            state_d  = DONE;
`ifdef DIV_REUSE_EN
                            ca_d = A;
                            cb_d = B;
                            cs_d = op_signed;
                            cq_d = sp_quot;
                            cr_d = sp_rem;
                            cv_d = 1'b1;
`endif
                        end else begin
                            dq_d    = A;
                            dvs_d   = B;
                            sgn_d   = op_signed;
                            isrem_d = op_rem;
                            state_d = PREP;
`ifdef DIV_REUSE_EN
                            opa_d = A;
                            opb_d = B;
`endif
                        end
                    end
                end
                PREP: begin
                    if (sgn_q) begin
                        dq_d   = abs_dq;
                        dvs_d  = abs_dvs;
                        qneg_d = dq_q[n-1] ^ dvs_q[n-1];
                        rneg_d = dq_q[n-1];
                    end else begin
                        qneg_d = 1'b0;
                        rneg_d = 1'b0;
                    end
                    rem_d   = '0;
                    cnt_d   = CNT_W'(n - 1);
                    state_d = RUN;
                end
                RUN: begin
                    rem_d = step_rem;
                    dq_d  = {dq_q[n-2:0], step_qbit};
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    result_d = isrem_q ? r_fin : q_fin;
                    state_d  = DONE;
`ifdef DIV_REUSE_EN
                    ca_d = opa_q;
                    cb_d = opb_q;
                    cs_d = sgn_q;
                    cq_d = q_fin;
                    cr_d = r_fin;
                    cv_d = 1'b1;
`endif
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= IDLE;
            dq_q     <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            sgn_q    <= 1'b0;
            isrem_q  <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef DIV_REUSE_EN
            opa_q <= '0;
            opb_q <= '0;
            ca_q  <= '0;
            cb_q  <= '0;
            cs_q  <= 1'b0;
            cq_q  <= '0;
            cr_q  <= '0;
            cv_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            dq_q     <= dq_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            sgn_q    <= sgn_d;
            isrem_q  <= isrem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef DIV_REUSE_EN
            opa_q <= opa_d;
            opb_q <= opb_d;
            ca_q  <= ca_d;
            cb_q  <= cb_d;
            cs_q  <= cs_d;
            cq_q  <= cq_d;
            cr_q  <= cr_d;
            cv_q  <= cv_d;
`endif
        end
    end

    // A Flush in the DONE cycle must still hide the completion pulse
    assign Done   = done_q & ~Flush;
    assign Busy   = busy_q;
    assign Result = result_q;

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for the RISC-V M-extension divide/remainder operations: DIV, DIVU, REM and REMU.
- The combinational ALU leaves these operations unimplemented.
- The block accepts an operation from the execute stage, runs an n-iteration restoring shift/subtract loop, applies sign correction, and returns a result with a done pulse.
- The execute stage stalls on busy.

Parameters:
- n, 32, operand/result width in bits (n >= 4, even).

Ports:
- clock, input, 1: system clock, rising edge.
- nReset, input, 1: asynchronous active-low reset.
- Start, input, 1: request strobe, sampled only in IDLE.
- AluOp, input, 5: operation code, sampled with Start.
  - 5'b10001 DIV, 5'b10101 DIVU, 5'b11001 REM, 5'b11101 REMU.
- A, input, n: dividend, sampled with Start.
- B, input, n: divisor, sampled with Start.
- Flush, input, 1: pipeline kill; aborts any in-flight operation.
- Busy, output, 1: high in every non-IDLE state.
- Done, output, 1: one-cycle pulse; Result is valid in that cycle.
- Result, output, n: quotient or remainder; held until the next Done.

Behaviour:
- Reset (nReset low, asynchronous): state IDLE, Busy=0, Done=0, Result=0, all internal registers cleared. Reset mid-operation discards the operation; no Done is produced.
- States and transitions:
  - IDLE -> PREP on Start with a divide opcode.
  - IDLE -> DONE on Start when a special case applies.
  - PREP -> RUN -> FIX -> DONE -> IDLE.
- Non-divide opcode with Start: ignored; stays IDLE, no Done.
- PREP (1 cycle):
  - Signed ops (DIV/REM): latch |A| and |B| and record the result sign.
    - Quotient sign = A[n-1]^B[n-1].
    - Remainder sign = A[n-1].
  - Unsigned ops: latch raw values.
- RUN (exactly n cycles): iteration counter counts n-1 down to 0. Each cycle:
  - Remainder register shifts left, taking the next dividend MSB.
  - Trial subtraction of the divisor.
  - Restore when the difference is negative.
  - Quotient bit shifts in.
- FIX (1 cycle): negate quotient/remainder when the recorded sign is set; select quotient (DIV/DIVU) or remainder (REM/REMU) into Result.
- DONE (1 cycle): Done=1, Busy=1; next state IDLE.
- Latency: Start accepted in cycle 0 -> Done in cycle n+3 (35 for n=32). Back-to-back: a new Start is accepted in the cycle after Done.
- Special cases, resolved in one cycle (Start in cycle 0 -> Done in cycle 1):
  - B==0: quotient = all ones; remainder = A (both signed and unsigned).
  - Signed overflow (A = 1<<(n-1), B = all ones): quotient = A; remainder = 0.
- Start while Busy: ignored; the operation is not queued.
- Flush: forces IDLE on the next edge from any state and suppresses Done, including when Flush coincides with the DONE state. Start in the same cycle as Flush while IDLE is ignored. Result keeps its previous value.
- Width rules:
  - Remainder register is n+1 bits, so the subtraction sign is visible.
  - Absolute value of the most negative number is handled as unsigned n-bit.
  - Negation is two's complement modulo 2^n.

Optional Feature:
- Macro: DIV_REUSE_EN.
- Defined:
  - Block keeps the last completed operation's A, B, signedness, quotient and remainder, plus a valid bit.
  - A Start whose A, B and signedness match a valid entry goes IDLE -> DONE, giving Done in cycle 1 with the cached quotient or remainder. This covers DIV followed by REM on the same operands.
  - Entry is written in FIX, or on a special-case completion.
  - Valid bit is cleared by reset; Flush does not clear it.
- Undefined: no cache storage; every op follows normal latency.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams OP_DIV, OP_DIVU, OP_REM, OP_REMU.
  - Enum typedef div_state_t {IDLE, PREP, RUN, FIX, DONE}.
  - Helper functions is_div_op and is_signed_div.
- One sub-module, div_step: a combinational single restoring iteration.
  - Inputs: remainder (n+1), dividend MSB, divisor (n).
  - Outputs: next remainder, quotient bit.

Test Plan:
- DIV A=20, B=3: Done exactly 35 cycles after Start, Result=6. REMU same operands: Result=2. Busy high cycles 1..35.
- DIV A=-7, B=2: Result=0xFFFFFFFD (-3). REM A=-7, B=2: Result=0xFFFFFFFF (-1). REM A=7, B=-2: Result=1.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, Done in cycle 1. REM 5/0 -> 5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Start DIV 100/7, pulse Flush in cycle 10: no Done ever, Busy low at cycle 11, Result unchanged. Start again at cycle 12 -> Result=14 at cycle 47.
- Start while Busy (second op at cycle 5): ignored; only one Done. Start with AluOp=5'b00000: no Busy, no Done. nReset low at cycle 20: all outputs 0 immediately.
- With DIV_REUSE_EN: DIV 1000/33 -> 30 at cycle 35; then REM 1000/33 -> 10, Done 1 cycle after Start. Without the macro, the same REM takes 35 cycles.
